// File: rtl/turf_hold_scheduler.sv
// turf_hold_scheduler: arbitrates trigger sources onto a ring of four SURF HOLD buffers and stamps event IDs
module turf_hold_scheduler #(
  parameter int HOLDOFF  = 8,
  parameter int EVID_LOW = 20
) (
  input  logic        clk33_i,
  input  logic        rst_i,
  input  logic [3:0]  trig_req_i,
  input  logic        disable_i,
  input  logic        clr_evt_i,
  input  logic        evid_reset_i,
  input  logic [11:0] epoch_i,
  output logic [3:0]  hold_o,
  output logic        trig_valid_o,
  output logic [1:0]  trig_buf_o,
  output logic [3:0]  trig_type_o,
  output logic [31:0] event_id_o,
  output logic [31:0] buf_status_o
);
  typedef enum logic [1:0] {IDLE, ASSIGN, WAIT} state_t;
  localparam logic [31:0] LOW_MASK = (32'h1 << EVID_LOW) - 32'h1;
  state_t      state;
  logic [3:0]  pending, win;
  logic [1:0]  wp, rp;
  logic [2:0]  cnt;
  logic [7:0]  hcnt;
  logic [15:0] dropped;
  logic [31:0] evid;
  logic        full, decide, accept, drop, rel;
  always_comb begin
    win    = pending[1] ? 4'b0010 : pending[2] ? 4'b0100 : pending[3] ? 4'b1000 : pending[0] ? 4'b0001 : 4'b0000;
    full   = cnt == 3'd4;
    decide = state == IDLE && !disable_i && |pending;
    accept = decide && !full;
    drop   = decide && full;
    rel    = clr_evt_i && cnt != 3'd0;
  end
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      state        <= IDLE;
      pending      <= '0;
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
      hcnt         <= '0;
      dropped      <= '0;
      evid         <= '0;
      hold_o       <= '0;
      trig_valid_o <= 1'b0;
      trig_buf_o   <= '0;
      trig_type_o  <= '0;
      event_id_o   <= '0;
      buf_status_o <= '0;
    end else begin
      // a drop discards every pending source, an accept only the winner
      pending      <= disable_i ? 4'b0000 : (pending & ~(drop ? 4'b1111 : accept ? win : 4'b0000)) | trig_req_i;
      state        <= state == IDLE ? (accept ? ASSIGN : IDLE) : state == ASSIGN ? (HOLDOFF > 0 ? WAIT : IDLE) : (hcnt == 8'd0 ? IDLE : WAIT);
      hcnt         <= state == ASSIGN ? 8'(HOLDOFF - 1) : state == WAIT ? hcnt - 8'd1 : hcnt;
      trig_valid_o <= accept;
      hold_o       <= (hold_o & ~(rel ? 4'b0001 << rp : 4'b0000)) | (accept ? 4'b0001 << wp : 4'b0000);
      wp           <= accept ? wp + 2'd1 : wp;
      rp           <= rel ? rp + 2'd1 : rp;
      cnt          <= cnt + 3'(accept) - 3'(rel);
      dropped      <= dropped + 16'(drop && dropped != 16'hFFFF);
      evid         <= evid_reset_i ? 32'(epoch_i) << EVID_LOW : accept ? (evid & ~LOW_MASK) | ((evid + 32'd1) & LOW_MASK) : evid;
      trig_buf_o   <= accept ? wp : trig_buf_o;
      trig_type_o  <= accept ? win : trig_type_o;
      event_id_o   <= accept ? evid : event_id_o;
      buf_status_o <= {dropped, 1'b0, disable_i, state != IDLE, full, rp, wp, 1'b0, cnt, hold_o};
    end
  end
endmodule

// File: tb/tb_turf_hold_scheduler.sv
// tb_turf_hold_scheduler: directed scenarios plus randomized traffic against a queue-based reference model
module tb_turf_hold_scheduler;
  localparam int HOLDOFF = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, disable_i = 1'b0, clr = 1'b0, evr = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] epoch = '0;
  logic [3:0]  hold_o, trig_type_o;
  logic        trig_valid_o;
  logic [1:0]  trig_buf_o;
  logic [31:0] event_id_o, buf_status_o;
  logic        clr2 = 1'b0, evr2 = 1'b0;
  logic [3:0]  req2 = '0;
  logic [11:0] epoch2 = '0;
  logic [3:0]  hold2, type2;
  logic        valid2;
  logic [1:0]  buf2;
  logic [31:0] id2, stat2;
  int n_checks = 0, n_fail = 0;

  turf_hold_scheduler #(.HOLDOFF(HOLDOFF), .EVID_LOW(20)) dut (
    .clk33_i(clk), .rst_i(rst), .trig_req_i(req), .disable_i(disable_i), .clr_evt_i(clr),
    .evid_reset_i(evr), .epoch_i(epoch), .hold_o(hold_o), .trig_valid_o(trig_valid_o),
    .trig_buf_o(trig_buf_o), .trig_type_o(trig_type_o), .event_id_o(event_id_o), .buf_status_o(buf_status_o));

  turf_hold_scheduler #(.HOLDOFF(0), .EVID_LOW(3)) u2 (
    .clk33_i(clk), .rst_i(rst), .trig_req_i(req2), .disable_i(1'b0), .clr_evt_i(clr2),
    .evid_reset_i(evr2), .epoch_i(epoch2), .hold_o(hold2), .trig_valid_o(valid2),
    .trig_buf_o(buf2), .trig_type_o(type2), .event_id_o(id2), .buf_status_o(stat2));

  // reference model: held buffers as a FIFO of indices, dead time as a "ready at cycle" timestamp
  int          m_cyc = 0, m_ready = 0, m_drop = 0, sz;
  int          q[$];
  logic [1:0]  m_wp = '0;
  logic [3:0]  m_pend = '0, w;
  logic [31:0] m_evid = '0;
  logic        acc, drp, rl;
  logic        exp_valid = 1'b0;
  logic [1:0]  exp_buf = '0;
  logic [3:0]  exp_type = '0, exp_hold = '0;
  logic [31:0] exp_id = '0, exp_status = '0;

  function automatic logic [3:0] qhold();
    logic [3:0] h = '0;
    foreach (q[i]) h[q[i]] = 1'b1;
    return h;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 0; m_drop = 0; q.delete(); m_wp = '0; m_pend = '0; m_evid = '0; m_cyc = 0;
      exp_valid = 1'b0; exp_buf = '0; exp_type = '0; exp_hold = '0; exp_id = '0; exp_status = '0;
    end else begin
      sz = q.size();
      exp_status = {m_drop[15:0], 1'b0, disable_i, m_cyc < m_ready, sz == 4, m_wp - 2'(sz), m_wp, 1'b0, 3'(sz), qhold()};
      w = m_pend[1] ? 4'b0010 : m_pend[2] ? 4'b0100 : m_pend[3] ? 4'b1000 : m_pend[0] ? 4'b0001 : 4'b0000;
      acc = m_cyc >= m_ready && !disable_i && m_pend != 0 && sz < 4;
      drp = m_cyc >= m_ready && !disable_i && m_pend != 0 && sz == 4;
      rl  = clr && sz > 0;
      exp_valid = acc;
      if (acc) begin
        exp_buf = m_wp; exp_type = w; exp_id = m_evid;
        q.push_back(int'(m_wp));
        m_wp = m_wp + 2'd1;
        m_ready = m_cyc + 2 + HOLDOFF;
      end
      if (rl) void'(q.pop_front());
      if (drp && m_drop < 65535) m_drop++;
      m_pend = disable_i ? 4'b0000 : (drp ? 4'b0000 : acc ? m_pend & ~w : m_pend) | req;
      if (evr) m_evid = {epoch, 20'h0};
      else if (acc) m_evid = {m_evid[31:20], m_evid[19:0] + 20'd1};
      exp_hold = qhold();
      m_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; clr = 1'b0; evr = 1'b0; disable_i = 1'b0; req2 = '0; clr2 = 1'b0; evr2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse_req(input logic [3:0] r);
    req = r; tick(); req = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({hold_o, trig_valid_o, trig_buf_o, trig_type_o, event_id_o} !== 43'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {hold_o, trig_valid_o, trig_buf_o, trig_type_o, event_id_o});
    end
    n_checks++;
    if (buf_status_o !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", buf_status_o); end
  endtask

  task automatic test_single();
    do_reset();
    pulse_req(4'b0001);
    n_checks++;
    if (trig_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early: valid got %b expected 0", trig_valid_o); end
    tick();
    n_checks++;
    if ({trig_valid_o, hold_o, trig_type_o, trig_buf_o, event_id_o} !== {1'b1, 4'b0001, 4'b0001, 2'd0, 32'd0}) begin
      n_fail++; $display("FAIL single_accept: got %h expected %h", {trig_valid_o, hold_o, trig_type_o, trig_buf_o, event_id_o}, {1'b1, 4'b0001, 4'b0001, 2'd0, 32'd0});
    end
    tick();
    n_checks++;
    if ({trig_valid_o, buf_status_o[6:4]} !== {1'b0, 3'd1}) begin
      n_fail++; $display("FAIL single_after: valid/cnt got %h expected %h", {trig_valid_o, buf_status_o[6:4]}, {1'b0, 3'd1});
    end
  endtask

  task automatic test_priority();
    int c = 2;
    do_reset();
    pulse_req(4'b0011);
    tick();
    n_checks++;
    if ({trig_valid_o, trig_type_o, trig_buf_o} !== {1'b1, 4'b0010, 2'd0}) begin
      n_fail++; $display("FAIL prio_first: got %h expected %h", {trig_valid_o, trig_type_o, trig_buf_o}, {1'b1, 4'b0010, 2'd0});
    end
    for (int k = 0; k < 40; k++) begin
      tick(); c++;
      if (trig_valid_o) break;
    end
    n_checks++;
    if (c !== 12) begin n_fail++; $display("FAIL prio_spacing: second accept at cycle %0d expected 12", c); end
    n_checks++;
    if ({trig_type_o, trig_buf_o, event_id_o} !== {4'b0001, 2'd1, 32'd1}) begin
      n_fail++; $display("FAIL prio_second: got %h expected %h", {trig_type_o, trig_buf_o, event_id_o}, {4'b0001, 2'd1, 32'd1});
    end
  endtask

  task automatic test_full_drop();
    int nv = 0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      pulse_req(4'b1000);
      if (trig_valid_o) nv++;
      for (int j = 0; j < 19; j++) begin tick(); if (trig_valid_o) nv++; end
    end
    n_checks++;
    if (nv !== 4) begin n_fail++; $display("FAIL full_accepts: got %0d expected 4", nv); end
    n_checks++;
    if ({hold_o, buf_status_o[31:16], buf_status_o[12]} !== {4'b1111, 16'd1, 1'b1}) begin
      n_fail++; $display("FAIL full_drop: hold/dropped/full got %h expected %h", {hold_o, buf_status_o[31:16], buf_status_o[12]}, {4'b1111, 16'd1, 1'b1});
    end
    clr = 1'b1; tick(); clr = 1'b0;
    n_checks++;
    if (hold_o !== 4'b1110) begin n_fail++; $display("FAIL full_release: hold got %b expected 1110", hold_o); end
    tick();
    n_checks++;
    if ({buf_status_o[11:10], buf_status_o[6:4]} !== {2'd1, 3'd3}) begin
      n_fail++; $display("FAIL full_rp: rp/cnt got %h expected %h", {buf_status_o[11:10], buf_status_o[6:4]}, {2'd1, 3'd3});
    end
  endtask

  task automatic test_wrap_simul();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pulse_req(4'b1000); tick();
      n_checks++;
      if ({trig_valid_o, trig_buf_o} !== {1'b1, 2'(i % 4)}) begin
        n_fail++; $display("FAIL wrap_buf%0d: got %h expected %h", i, {trig_valid_o, trig_buf_o}, {1'b1, 2'(i % 4)});
      end
      clr = 1'b1; tick(); clr = 1'b0;
      n_checks++;
      if (hold_o !== 4'b0000) begin n_fail++; $display("FAIL wrap_clear%0d: hold got %b expected 0000", i, hold_o); end
      repeat (10) tick();
    end
    pulse_req(4'b1000); tick();
    repeat (10) tick();
    req = 4'b1000; tick(); req = '0; clr = 1'b1; tick(); clr = 1'b0;
    n_checks++;
    if ({trig_valid_o, trig_buf_o, hold_o} !== {1'b1, 2'd3, 4'b1000}) begin
      n_fail++; $display("FAIL simul_hold: got %h expected %h", {trig_valid_o, trig_buf_o, hold_o}, {1'b1, 2'd3, 4'b1000});
    end
    tick();
    n_checks++;
    if ({buf_status_o[11:8], buf_status_o[6:4]} !== {2'd3, 2'd0, 3'd1}) begin
      n_fail++; $display("FAIL simul_ptrs: rp/wp/cnt got %h expected %h", {buf_status_o[11:8], buf_status_o[6:4]}, {2'd3, 2'd0, 3'd1});
    end
  endtask

  task automatic test_evid();
    int nv = 0, last = 0;
    do_reset();
    epoch = 12'hABC; evr = 1'b1; tick(); evr = 1'b0;
    pulse_req(4'b0100); tick();
    n_checks++;
    if (event_id_o !== 32'hABC00000) begin n_fail++; $display("FAIL evid_reload: got %h expected abc00000", event_id_o); end
    repeat (10) tick();
    pulse_req(4'b0100); tick();
    n_checks++;
    if (event_id_o !== 32'hABC00001) begin n_fail++; $display("FAIL evid_incr: got %h expected abc00001", event_id_o); end
    epoch2 = 12'h005; evr2 = 1'b1; tick(); evr2 = 1'b0;
    req2 = 4'b0001; clr2 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (valid2) begin
        n_checks++;
        if ({id2, type2, buf2} !== {32'h28 + 32'(nv % 8), 4'b0001, 2'(nv % 4)}) begin
          n_fail++; $display("FAIL evid_wrap%0d: got %h expected %h", nv, {id2, type2, buf2}, {32'h28 + 32'(nv % 8), 4'b0001, 2'(nv % 4)});
        end
        if (nv > 0) begin
          n_checks++;
          if (c - last !== 2) begin n_fail++; $display("FAIL zero_holdoff_spacing: got %0d expected 2", c - last); end
        end
        last = c; nv++;
      end
    end
    req2 = '0;
    repeat (4) tick();
    clr2 = 1'b0;
    n_checks++;
    if (nv < 17 || hold2 !== 4'b0000 || stat2[6:4] !== 3'd0) begin
      n_fail++; $display("FAIL evid_wrap_end: accepts %0d hold %b cnt %0d expected >=17, 0000, 0", nv, hold2, stat2[6:4]);
    end
  endtask

  task automatic test_disable_reset();
    int nv = 0;
    do_reset();
    pulse_req(4'b1000); tick(); tick();
    req = 4'b0101; tick(); req = '0; tick();
    disable_i = 1'b1;
    repeat (3) begin tick(); if (trig_valid_o) nv++; end
    n_checks++;
    if (buf_status_o[14] !== 1'b1) begin n_fail++; $display("FAIL disable_status: got %b expected 1", buf_status_o[14]); end
    repeat (10) begin tick(); if (trig_valid_o) nv++; end
    disable_i = 1'b0;
    repeat (20) begin tick(); if (trig_valid_o) nv++; end
    n_checks++;
    if (nv !== 0 || hold_o !== 4'b0001) begin n_fail++; $display("FAIL disable_drop: accepts %0d hold %b expected 0, 0001", nv, hold_o); end
    do_reset();
    pulse_req(4'b1000); tick();
    repeat (10) tick();
    pulse_req(4'b1000); tick();
    n_checks++;
    if (hold_o !== 4'b0011) begin n_fail++; $display("FAIL reset_setup: hold got %b expected 0011", hold_o); end
    tick(); tick();
    rst = 1'b1; tick();
    n_checks++;
    if ({hold_o, trig_valid_o, trig_buf_o, trig_type_o, event_id_o, buf_status_o} !== 75'd0) begin
      n_fail++; $display("FAIL reset_mid_holdoff: got %h expected 0", {hold_o, trig_valid_o, trig_buf_o, trig_type_o, event_id_o, buf_status_o});
    end
    rst = 1'b0; tick();
    n_checks++;
    if (buf_status_o[13] !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy got %b expected 0", buf_status_o[13]); end
    pulse_req(4'b0001); tick();
    n_checks++;
    if ({trig_valid_o, trig_buf_o} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL reset_restart: got %h expected %h", {trig_valid_o, trig_buf_o}, {1'b1, 2'd0});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req = {$urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0};
      clr = $urandom_range(0, 6) == 0;
      evr = $urandom_range(0, 60) == 0;
      epoch = 12'($urandom);
      if ($urandom_range(0, 40) == 0) disable_i = ~disable_i;
      tick();
      n_checks++;
      if ({trig_valid_o, trig_buf_o, trig_type_o, event_id_o, hold_o, buf_status_o} !== {exp_valid, exp_buf, exp_type, exp_id, exp_hold, exp_status}) begin
        n_fail++; $display("FAIL random_c%0d: got %h expected %h", c, {trig_valid_o, trig_buf_o, trig_type_o, event_id_o, hold_o, buf_status_o}, {exp_valid, exp_buf, exp_type, exp_id, exp_hold, exp_status});
      end
    end
    req = '0; clr = 1'b0; evr = 1'b0; disable_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_full_drop();
    test_wrap_simul();
    test_evid();
    test_disable_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/turf_hold_scheduler.md
# turf_hold_scheduler

Trigger sequencer for the TURF trigger path in the CLK33 domain. It collects single-cycle trigger requests from four sources: RF/L1, PPS1, PPS2, and soft-or-external. A fixed-priority arbiter picks one winner, and the block allocates the next free buffer out of four SURF HOLD buffers in ring order. It then drives the per-buffer hold levels that are fanned out to all SURFs, and stamps each accepted trigger with an event ID built from the epoch. Buffers are released in order by `clr_evt_i` pulses from the register interface, and the block reports its occupancy, pointers and dropped-trigger count in `buf_status_o`.

## Interface
Parameters:
- `HOLDOFF`, 8: number of dead cycles after each assignment (0–255).
- `EVID_LOW`, 20: width of the wrapping low event-ID field; the epoch occupies bits [31:EVID_LOW].

Ports:
- `clk33_i`  in  1  33 MHz system clock; the only clock.
- `rst_i`  in  1  reset, synchronous and active-high.
- `trig_req_i`  in  4  trigger request pulses: [0] RF, [1] PPS1, [2] PPS2, [3] soft/ext. Each is one cycle per request.
- `disable_i`  in  1  master event disable, level.
- `clr_evt_i`  in  1  one-cycle pulse: readout done, release the oldest held buffer.
- `evid_reset_i`  in  1  one-cycle pulse: reload the event ID.
- `epoch_i`  in  12  epoch value loaded on `evid_reset_i`.
- `hold_o`  out  4  per-buffer HOLD level.
- `trig_valid_o`  out  1  one-cycle pulse per accepted trigger.
- `trig_buf_o`  out  2  buffer assigned to the accepted trigger; valid with `trig_valid_o`.
- `trig_type_o`  out  4  one-hot winning source; valid with `trig_valid_o`.
- `event_id_o`  out  32  ID of the accepted event; valid with `trig_valid_o`.
- `buf_status_o`  out  32  status word for register readback (field layout under Operation).

## Operation
- **Pending register (4 bits).**
  - A request bit is set by `trig_req_i[k]`.
  - A repeated request from a source that is already pending merges into the existing bit and is not counted.
  - While `disable_i` is high, all pending bits are forced to 0 and new requests are ignored.
- **Buffer ring.**
  - State is write pointer `wp`, read pointer `rp` (both 2 bits, wrapping 3→0) and `cnt` (0–4).
  - `full` = (`cnt`==4).
- **FSM states: IDLE, ASSIGN, HOLDOFF.**
  - IDLE → ASSIGN when any pending bit is set and `!full`.
    - The winner is chosen by fixed priority: PPS1 > PPS2 > soft/ext > RF.
    - The winner's pending bit is cleared.
  - IDLE with any pending bit set and `full`: all pending bits are cleared, `dropped` increments by 1 (16-bit, saturating at 0xFFFF), and the FSM stays in IDLE.
  - ASSIGN (one cycle):
    - Assert `trig_valid_o`, set `hold_o[wp]`, drive `trig_buf_o`=`wp`, and drive `event_id_o` with the current ID.
    - Then `wp`++, `cnt`++, and the ID low field increments.
  - ASSIGN → HOLDOFF if `HOLDOFF`>0, otherwise → IDLE.
  - HOLDOFF: stay for exactly `HOLDOFF` cycles, then → IDLE. Requests arriving during ASSIGN/HOLDOFF remain pending.
- **Release.**
  - `clr_evt_i` with `cnt`>0 clears `hold_o[rp]`, then `rp`++ and `cnt`--.
  - `clr_evt_i` with `cnt`==0 is ignored.
  - If ASSIGN and `clr_evt_i` occur in the same cycle, both take effect: `cnt` is unchanged, the hold bit at `wp` is set and the hold bit at `rp` is cleared.
- **Event ID.**
  - The low `EVID_LOW` bits wrap from all-ones to 0 without carrying into the epoch field.
  - `evid_reset_i` loads {`epoch_i`, `EVID_LOW`'b0}.
  - If `evid_reset_i` coincides with ASSIGN, the assigned event carries the old ID and the reload takes precedence over the increment.
- **`buf_status_o` fields.**
  - [3:0] `hold_o`
  - [6:4] `cnt`
  - [9:8] `wp`
  - [11:10] `rp`
  - [12] `full`
  - [13] state != IDLE
  - [14] `disable_i`
  - [15] 0
  - [31:16] `dropped`
- **Reset.** All state and outputs go to 0: `hold_o`=0, pending=0, FSM=IDLE, pointers/`cnt`/`dropped`=0, event ID=0, `trig_valid_o`=0. Reset in the middle of a HOLDOFF aborts it immediately.

## Timing
- All outputs are registered.
- Request-to-accept latency is 2 cycles: `trig_req_i` high in cycle N → pending set in N+1 (FSM in IDLE) → `trig_valid_o` and `hold_o` asserted in N+2.
- The minimum spacing between `trig_valid_o` pulses is `HOLDOFF`+2 cycles.
- Release latency is 1 cycle: `clr_evt_i` high in cycle N → `hold_o` bit low in N+1.
- The status word lags the internal state by 1 cycle.
- `trig_buf_o`, `trig_type_o` and `event_id_o` hold their values until the next accept.

## Test plan
- **Single trigger:** `HOLDOFF`=8, one RF pulse at cycle 0 → `trig_valid_o` high at cycle 2 only, `hold_o`=0001, `trig_type_o`=0001, `event_id_o`=0, `buf_status_o`[6:4]=1.
- **Priority and holdoff:** RF and PPS1 pulse together → PPS1 accepted at cycle 2 on buffer 0, RF accepted at cycle 12 on buffer 1 with `event_id_o`=1.
- **Full and drop:** 5 soft pulses spaced 20 cycles apart with no clears → `hold_o`=1111 after 4 accepts; the 5th is dropped with no `trig_valid_o` and `dropped`=1. A `clr_evt_i` pulse then gives `hold_o`=1110 and `rp`=1.
- **Wrap and simultaneous events:** run more than 4 accept/clear cycles so the pointers wrap 3→0 correctly. Fire `clr_evt_i` in the same cycle as ASSIGN → `cnt` is unchanged and both hold bits update.
- **Event ID reload and wrap:** `EVID_LOW`=20, `epoch_i`=0xABC, pulse `evid_reset_i`, then trigger → `event_id_o`=0xABC00000. Force the low field to 0xFFFFF; the next trigger gives 0xABC00000 again.
- **Disable and reset:** assert `disable_i` while 2 requests are pending → no accepts and pending cleared. Assert `rst_i` mid-HOLDOFF with `hold_o`=0011 → all outputs are 0 on the next cycle and FSM=IDLE.
